// File: rtl/mux_scan_n.sv
// N-channel W-bit registered multiplexer.
// Manual select or self-stepping scan with programmable dwell.
module mux_scan_n #(
    parameter int W     = 8,
    parameter int N     = 8,
    parameter int SELW  = 3,
    parameter int DWELL = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  x,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    o,
    output logic [SELW-1:0] ch,
    output logic            o_valid,
    output logic            wrap,
    output logic            sel_err
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW-1:0] LAST = SELW'(N - 1);
    localparam logic [CW-1:0]   CMAX = CW'(DWELL - 1);

    logic [CW-1:0]   cnt;
    logic            mode_q;
    logic            first;
    logic [SELW-1:0] ch_nxt;
    logic [W-1:0]    d_sel;
    logic [W-1:0]    d_cur;
    logic [W-1:0]    d_nxt;
    logic            sel_ok;
    logic            expire;

    always_comb begin
        sel_ok = {1'b0, sel} < (SELW+1)'(N);
        ch_nxt = (ch == LAST) ? '0 : ch + 1'b1;
        expire = (cnt == CMAX);
        d_sel  = '0;
        d_cur  = '0;
        d_nxt  = '0;
        // Explicit decode keeps unused select codes from indexing past x.
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k))
                d_sel = x[k*W +: W];
            if (ch == SELW'(k))
                d_cur = x[k*W +: W];
            if (ch_nxt == SELW'(k))
                d_nxt = x[k*W +: W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o       <= '0;
            ch      <= '0;
            o_valid <= 1'b0;
            wrap    <= 1'b0;
            sel_err <= 1'b0;
            cnt     <= '0;
            mode_q  <= 1'b0;
            first   <= 1'b1;
        end else if (!en) begin
            o_valid <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            mode_q <= mode;
            wrap   <= 1'b0;
            if (mode) begin
                sel_err <= 1'b0;
                first   <= 1'b0;
                if (!mode_q) begin
                    ch      <= '0;
                    cnt     <= '0;
                    o       <= x[W-1:0];
                    o_valid <= 1'b1;
                end else if (expire) begin
                    cnt     <= '0;
                    ch      <= ch_nxt;
                    o       <= d_nxt;
                    o_valid <= 1'b1;
                    wrap    <= (ch == LAST);
                end else begin
                    cnt     <= cnt + 1'b1;
                    o       <= d_cur;
                    o_valid <= 1'b0;
                end
            end else begin
                cnt <= '0;
                if (sel_ok) begin
                    o       <= d_sel;
                    ch      <= sel;
                    o_valid <= first || (sel != ch);
                    sel_err <= 1'b0;
                    first   <= 1'b0;
                end else begin
                    o       <= '0;
                    o_valid <= 1'b0;
                    sel_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
Parametrised N-channel, W-bit registered multiplexer. It generalises the fixed 8:1 x 8-bit channel selector with two modes. In manual mode an external select picks the channel. In scan mode the block steps through all channels itself, holding each for a programmable dwell time. It sits between the multi-source data buses and single-consumer logic such as a display, a UART or a capture buffer.

Parameters:
W, 8, data width per channel (>=1)
N, 8, channel count (2..256)
SELW, 3, select width; must satisfy 2**SELW >= N
DWELL, 4, cycles each channel is held in scan mode (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
x  in  N*W  packed channel inputs; channel k = x[k*W +: W]
sel  in  SELW  manual channel select
mode  in  1  0 = manual, 1 = scan
en  in  1  clock enable; 0 freezes all state
o  out  W  registered selected data
ch  out  SELW  channel currently driving o
o_valid  out  1  one-cycle pulse: first cycle o reflects a new channel
wrap  out  1  one-cycle pulse: scan advanced from channel N-1 to 0
sel_err  out  1  registered; 1 while manual sel >= N

Behaviour:
- Reset (rst_n=0, asynchronous):
  - o=0, ch=0, o_valid=0, wrap=0, sel_err=0.
  - Dwell counter cleared to 0.
  - Internal mode register cleared to manual.
  - Outputs stay in this state until the first clk edge after rst_n rises.
- en=0:
  - o, ch, dwell counter, sel_err and the mode register hold.
  - o_valid=0 and wrap=0 on that cycle.
- All behaviour below applies only when en=1.
- Manual mode (mode=0):
  - Latency 1: o <= x[sel], ch <= sel on every edge.
  - o_valid=1 on the edge where the new ch differs from the old ch.
  - o_valid=1 on the first edge after reset.
  - Out-of-range sel (sel >= N): o <= 0, ch holds its previous value, sel_err=1, o_valid=0.
  - sel_err clears on the first edge with sel < N.
  - Dwell counter is held at 0.
- Scan mode (mode=1):
  - Entering scan (registered mode 0 -> 1): ch <= 0, counter <= 0, o <= x[0], o_valid=1.
  - While scanning, o <= x[ch] every edge, so live data on the current channel is tracked.
  - Counter increments each enabled cycle.
  - When counter == DWELL-1: counter <= 0, ch <= ch+1, o <= x[ch+1], o_valid=1.
  - When ch == N-1 at that point: ch <= 0, o <= x[0], wrap=1 together with o_valid.
  - Each channel therefore occupies exactly DWELL enabled cycles; a full sweep takes N*DWELL enabled cycles.
  - DWELL=1: the channel advances every cycle and o_valid is constantly 1.
  - sel and sel_err are ignored; sel_err is forced to 0.
- Leaving scan (mode 1 -> 0): the next edge applies the manual rule (ch <= sel). o_valid follows the manual rule. Counter is cleared.
- Priority (highest first): rst_n, then en=0, then mode transition, then dwell expiry.
- Arithmetic:
  - Counter width is clog2(DWELL) bits, minimum 1.
  - ch increments modulo N, not modulo 2**SELW.
- Unused select codes in N < 2**SELW configurations are never generated in scan mode.

Test Plan:
1. Defaults, mode=0. Channel k holds 8'h11*k. Step sel 0..7, 10 cycles each -> o equals 8'h11*sel one cycle after each change. ch=sel. o_valid pulses once per change.
2. Scan with defaults and the same data, mode=1 for 40 cycles -> o sequence 00 x4, 11 x4, … 77 x4. o_valid is asserted every 4th cycle. wrap=1 exactly at the 77 -> 00 transition (cycle 32 after entry).
3. Scan, DWELL=4: hold en=0 for 3 cycles mid-dwell on channel 5 -> o=8'h55, ch=5 and the counter are frozen. Channel 5 totals 4 enabled cycles. No o_valid or wrap during the freeze.
4. N=5, SELW=3, manual: sel=6 -> o=0, sel_err=1, ch holds the prior value. sel=2 -> o=x2, sel_err=0.
5. Scan, rst_n pulled low asynchronously mid-sweep at ch=3 (between edges) -> o=0 and ch=0 immediately. After release with mode=0, sel=4: o=x4 one cycle later with o_valid=1.
6. Switch mode 1 -> 0 with sel=2 while at ch=6 -> next edge ch=2, o=x2, o_valid=1. Switch back to mode=1 -> restarts at ch=0 with o_valid=1.
